// File: rtl/waveform_generator.sv
// waveform_generator: phase-accumulator test-tone source (saw/square/triangle/silence) with valid/ready output; optional amplitude scaling under WAVEGEN_AMPLITUDE_EN
module waveform_generator #(
    parameter int BIT_WIDTH   = 16,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                        clk_audio,
    input  logic                        reset_n,
    input  logic [PHASE_WIDTH-1:0]      increment,
    input  logic [1:0]                  mode,
    input  logic                        phase_reset,
    input  logic                        level_ready,
`ifdef WAVEGEN_AMPLITUDE_EN
    input  logic [BIT_WIDTH-1:0]        amplitude,
`endif
    output logic                        level_valid,
    output logic signed [BIT_WIDTH-1:0] level
);

    localparam logic [BIT_WIDTH:0] HALF = (BIT_WIDTH+1)'(1) << (BIT_WIDTH-1);

    logic [PHASE_WIDTH-1:0]      phase;
    logic                        msb;
    logic [BIT_WIDTH-1:0]        u;
    logic [BIT_WIDTH-1:0]        tri_fold;
    logic [BIT_WIDTH:0]          tri_full;
    logic signed [BIT_WIDTH-1:0] saw_val;
    logic signed [BIT_WIDTH-1:0] sq_val;
    logic signed [BIT_WIDTH-1:0] shape;
    logic signed [BIT_WIDTH-1:0] level_next;
    logic                        load;

    // Shape selection from the current phase; triangle folds the upper half so it rises first
    always_comb begin
        msb      = phase[PHASE_WIDTH-1];
        u        = phase[PHASE_WIDTH-2 -: BIT_WIDTH];
        tri_fold = msb ? ~u : u;
        tri_full = {1'b0, tri_fold} - HALF;
        saw_val  = $signed(phase[PHASE_WIDTH-1 -: BIT_WIDTH]);
        sq_val   = msb ? $signed({1'b1, {(BIT_WIDTH-1){1'b0}}}) : $signed({1'b0, {(BIT_WIDTH-1){1'b1}}});
        shape    = mode == 2'd0 ? saw_val :
                   mode == 2'd1 ? sq_val  :
                   mode == 2'd2 ? $signed(tri_full[BIT_WIDTH-1:0]) : '0;
    end

`ifdef WAVEGEN_AMPLITUDE_EN
    logic signed [2*BIT_WIDTH:0] prod;

    // Scale by an unsigned gain treated as a fraction of full scale (floor via arithmetic shift)
    always_comb begin
        prod       = shape * $signed({1'b0, amplitude});
        level_next = BIT_WIDTH'(prod >>> BIT_WIDTH);
    end
`else
    assign level_next = shape;
`endif

    assign load = !level_valid || level_ready;

    // Output register and phase accumulator; phase_reset wins and drops a sample only if the sink just took it
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else if (phase_reset) begin
            phase <= '0;
            if (level_ready)
                level_valid <= 1'b0;
        end else if (load) begin
            level       <= level_next;
            level_valid <= 1'b1;
            phase       <= phase + increment;
        end
    end

endmodule
